// File: rtl/max11046_emulator.sv
// MAX11046 parallel-bus ADC responder: synchronizes the controller strobes,
// times a conversion, and returns a held 8-channel sample set on DB in read order.
module max11046_emulator #(
  parameter int unsigned CONV_CYCLES = 400,
  parameter int unsigned NUM_CH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   convst,
  input  logic                   cs,
  input  logic                   rd,
  input  logic                   wr,
  input  logic                   shdn,
  input  logic [16*NUM_CH-1:0]   sample_data,
  input  logic [15:0]            db_in,
  output logic                   eoc,
  output logic [15:0]            db_out,
  output logic                   db_oe,
  output logic                   busy
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  // Sync chain order: {shdn, wr, rd, cs, convst}; strobes idle high, others low.
  localparam logic [4:0] SYNC_RST = 5'b01110;

  typedef enum logic [2:0] {IDLE, CONVERT, READY, READOUT, SHUTDOWN} state_t;

  state_t            state_q, state_d;
  logic [4:0]        sync1_q, sync2_q;
  logic [2:0]        dly_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
  logic [15:0]       hold_q [NUM_CH];
  logic [15:0]       hold_d [NUM_CH];
  logic [15:0]       db_out_q, db_out_d;
  logic              eoc_q, eoc_d;
  logic              fmt_q, fmt_d;

  logic convst_s, cs_n_s, rd_n_s, wr_n_s, shdn_s;
  logic convst_rise, rd_fall, wr_rise, read_req;
  logic [15:0] read_word;
  logic unused_db_in;

  assign convst_s = sync2_q[0];
  assign cs_n_s   = sync2_q[1];
  assign rd_n_s   = sync2_q[2];
  assign wr_n_s   = sync2_q[3];
  assign shdn_s   = sync2_q[4];

  assign convst_rise = convst_s & ~dly_q[0];
  assign rd_fall     = ~rd_n_s & dly_q[1];
  assign wr_rise     = wr_n_s & ~dly_q[2];
  assign read_req    = rd_fall & ~cs_n_s;

  // Two's-complement output is offset binary with the MSB flipped.
  assign read_word = hold_q[ch_idx_q] ^ {fmt_q, 15'b0};

  assign unused_db_in = ^db_in[15:1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ch_idx_d = ch_idx_q;
    hold_d   = hold_q;
    db_out_d = db_out_q;
    eoc_d    = eoc_q;
    fmt_d    = fmt_q;

    if (shdn_s) begin
      state_d = SHUTDOWN;
      eoc_d   = 1'b1;
    end else begin
      case (state_q)
        SHUTDOWN: state_d = IDLE;
        CONVERT: begin
          if (cnt_q == '0) begin
            state_d = READY;
            eoc_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: begin
          // convst has priority over a read detected in the same cycle.
          if (convst_rise) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
              hold_d[i] = sample_data[i*16 +: 16];
            end
            ch_idx_d = '0;
            cnt_d    = 16'(CONV_CYCLES - 1);
            state_d  = CONVERT;
            eoc_d    = 1'b1;
          end else if (read_req) begin
            db_out_d = read_word;
            ch_idx_d = (ch_idx_q == CH_W'(NUM_CH - 1)) ? '0 : ch_idx_q + 1'b1;
            eoc_d    = 1'b1;
            if (state_q == READY) begin
              state_d = READOUT;
            end else if (state_q == READOUT && ch_idx_q == CH_W'(NUM_CH - 1)) begin
              state_d = IDLE;
            end
          end
        end
      endcase
    end

    if (wr_rise && !cs_n_s && !shdn_s && state_q != SHUTDOWN) begin
      fmt_d = db_in[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= SYNC_RST;
      sync2_q  <= SYNC_RST;
      dly_q    <= 3'b110;
      state_q  <= IDLE;
      cnt_q    <= '0;
      ch_idx_q <= '0;
      hold_q   <= '{default: '0};
      db_out_q <= '0;
      eoc_q    <= 1'b1;
      fmt_q    <= 1'b0;
    end else begin
      sync1_q  <= {shdn, wr, rd, cs, convst};
      sync2_q  <= sync1_q;
      dly_q    <= {sync2_q[3], sync2_q[2], sync2_q[0]};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ch_idx_q <= ch_idx_d;
      hold_q   <= hold_d;
      db_out_q <= db_out_d;
      eoc_q    <= eoc_d;
      fmt_q    <= fmt_d;
    end
  end

  assign eoc    = eoc_q;
  assign busy   = (state_q == CONVERT);
  assign db_out = db_out_q;
  assign db_oe  = ~cs_n_s & ~rd_n_s & ~shdn_s & (state_q != SHUTDOWN);

endmodule

// File: tb/tb_max11046_emulator.sv
// Scoreboarded bench for max11046_emulator: expected DB words are queued as
// reads are issued and compared once the emulator presents them.
module tb_max11046_emulator;

  logic         clk = 1'b0;
  logic         reset, convst, cs, rd, wr, shdn;
  logic [127:0] sample_data;
  logic [15:0]  db_in;
  logic         eoc, db_oe, busy;
  logic [15:0]  db_out;

  int unsigned  checks = 0;
  int unsigned  failures = 0;
  logic [15:0]  exp_q[$];
  logic         fmt_m = 1'b0;

  always #5 clk = ~clk;

  max11046_emulator #(.CONV_CYCLES(10), .NUM_CH(8)) dut (
    .clk(clk), .reset(reset), .convst(convst), .cs(cs), .rd(rd), .wr(wr),
    .shdn(shdn), .sample_data(sample_data), .db_in(db_in),
    .eoc(eoc), .db_out(db_out), .db_oe(db_oe), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_samples(input logic [15:0] base);
    for (int n = 0; n < 8; n++) sample_data[n*16 +: 16] = base + 16'(n);
  endtask

  function automatic logic [15:0] model_word(input int n);
    logic [15:0] w;
    w = sample_data[n*16 +: 16];
    return w ^ {fmt_m, 15'b0};
  endfunction

  task automatic do_convert(input bit retrig);
    int t;
    int cnt;
    convst = 1'b1;
    t = 0;
    while (busy !== 1'b1 && t < 30) begin cyc(1); t++; end
    check("busy_rise", busy, 1);
    check("eoc_during_conv", eoc, 1);
    convst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (retrig && cnt == 2) convst = 1'b1;
      if (retrig && cnt == 6) convst = 1'b0;
      cyc(1);
    end
    check("busy_cycles", cnt, 10);
    check("eoc_fall", eoc, 0);
    cyc(2);
  endtask

  task automatic do_read(input logic [15:0] exp_word);
    int t;
    exp_q.push_back(exp_word);
    rd = 1'b0;
    t = 0;
    while (db_oe !== 1'b1 && t < 10) begin cyc(1); t++; end
    check("db_oe_rise", db_oe, 1);
    cyc(3);
    if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
    else check("db_out", db_out, exp_q.pop_front());
    check("eoc_after_read", eoc, 1);
    rd = 1'b1;
    cyc(6);
    check("db_oe_after_read", db_oe, 0);
  endtask

  task automatic write_fmt(input logic b);
    db_in = {15'b0, b};
    wr = 1'b0;
    cyc(6);
    wr = 1'b1;
    cyc(6);
    fmt_m = b;
  endtask

  initial begin
    int oe_seen;
    reset = 1'b1; convst = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; shdn = 1'b0;
    db_in = '0;
    load_samples(16'h1000);
    cyc(3);
    check("rst_eoc", eoc, 1);
    check("rst_busy", busy, 0);
    check("rst_db_out", db_out, 0);
    check("rst_db_oe", db_oe, 0);
    reset = 1'b0;
    cyc(4);

    // Basic conversion and full readout with wrap
    do_convert(1'b0);
    cs = 1'b0;
    cyc(4);
    for (int n = 0; n < 8; n++) do_read(model_word(n));
    do_read(model_word(0));

    // Output format selection
    sample_data[15:0] = 16'h8000;
    write_fmt(1'b1);
    do_convert(1'b0);
    do_read(model_word(0));
    check("fmt1_literal", db_out, 16'h0000);
    write_fmt(1'b0);
    do_convert(1'b0);
    do_read(model_word(0));
    check("fmt0_literal", db_out, 16'h8000);
    load_samples(16'h1000);

    // Retrigger during conversion, then restart mid-readout
    do_convert(1'b1);
    for (int n = 0; n < 3; n++) do_read(model_word(n));
    load_samples(16'h2000);
    do_convert(1'b0);
    do_read(model_word(0));
    do_read(model_word(1));

    // Shutdown mid-conversion
    convst = 1'b1;
    cyc(5);
    check("shdn_pre_busy", busy, 1);
    convst = 1'b0;
    cyc(2);
    shdn = 1'b1;
    cyc(5);
    check("shdn_busy", busy, 0);
    check("shdn_eoc", eoc, 1);
    oe_seen = 0;
    rd = 1'b0;
    for (int i = 0; i < 6; i++) begin cyc(1); if (db_oe === 1'b1) oe_seen++; end
    rd = 1'b1;
    cyc(6);
    check("shdn_db_oe", oe_seen, 0);
    check("shdn_eoc_hold", eoc, 1);
    shdn = 1'b0;
    cyc(5);
    load_samples(16'h3000);
    do_convert(1'b0);
    do_read(model_word(0));

    // Reset during readout
    load_samples(16'h1000);
    write_fmt(1'b1);
    do_convert(1'b0);
    for (int n = 0; n < 3; n++) do_read(model_word(n));
    reset = 1'b1;
    cyc(1);
    check("rst_mid_eoc", eoc, 1);
    check("rst_mid_db_oe", db_oe, 0);
    check("rst_mid_db_out", db_out, 0);
    check("rst_mid_busy", busy, 0);
    cyc(1);
    reset = 1'b0;
    fmt_m = 1'b0;
    cyc(5);
    do_convert(1'b0);
    do_read(model_word(0));
    check("post_rst_literal", db_out, 16'h1000);
    do_read(model_word(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
